// File: rtl/redirect_sched.sv
// redirect_sched: round-robin scheduler applying per-port redirect requests to the routing table after a crossbar drain.
// Optional drain timeout enabled by defining REDIRECT_SCHED_TIMEOUT_EN.
module redirect_sched #(
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_INIT = 2,
  parameter int DRAIN_TIMEOUT = 16,
  localparam int PW = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_TARG_PORT-1:0]            redirect_valid_i,
  input  logic [N_TARG_PORT*LOG_N_INIT-1:0] source_i,
  input  logic [N_TARG_PORT*LOG_N_INIT-1:0] target_i,
  input  logic                              xbar_idle_i,
  output logic                              cfg_valid_o,
  input  logic                              cfg_ready_i,
  output logic [PW-1:0]                     cfg_port_o,
  output logic                              cfg_enable_o,
  output logic [LOG_N_INIT-1:0]             cfg_source_o,
  output logic [LOG_N_INIT-1:0]             cfg_target_o,
  output logic [N_TARG_PORT-1:0]            active_o,
  output logic                              busy_o,
  output logic                              timeout_o
);
  localparam int L = LOG_N_INIT;
  localparam int NL = N_TARG_PORT * LOG_N_INIT;
  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_t;
  state_t state_q, state_d;
  logic [N_TARG_PORT-1:0] desired_q, active_q, active_d, req;
  logic [NL-1:0] src_q, tgt_q, app_src_q, app_src_d, app_tgt_q, app_tgt_d;
  logic [PW-1:0] rr_q, rr_d, port_q, port_d, gnt_idx;
  logic en_q, en_d, gnt_found, expire;
  logic [L-1:0] s_q, s_d, t_q, t_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      desired_q <= '0;
      src_q <= '0;
      tgt_q <= '0;
      active_q <= '0;
      app_src_q <= '0;
      app_tgt_q <= '0;
      rr_q <= '0;
      port_q <= '0;
      en_q <= 1'b0;
      s_q <= '0;
      t_q <= '0;
    end else begin
      state_q <= state_d;
      desired_q <= redirect_valid_i;
      src_q <= source_i;
      tgt_q <= target_i;
      active_q <= active_d;
      app_src_q <= app_src_d;
      app_tgt_q <= app_tgt_d;
      rr_q <= rr_d;
      port_q <= port_d;
      en_q <= en_d;
      s_q <= s_d;
      t_q <= t_d;
    end
  end
  // A still-wanted redirect whose pair changed is re-applied without removal first.
  always_comb begin
    req = '0;
    for (int p = 0; p < N_TARG_PORT; p++)
      req[p] = (desired_q[p] != active_q[p]) |
               (desired_q[p] & active_q[p] &
                ({src_q[p*L +: L], tgt_q[p*L +: L]} != {app_src_q[p*L +: L], app_tgt_q[p*L +: L]}));
  end
  // Descending scan so the lowest offset from the pointer wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    for (int i = N_TARG_PORT - 1; i >= 0; i--)
      if (req[(int'(rr_q) + i) % N_TARG_PORT]) begin
        gnt_found = 1'b1;
        gnt_idx = PW'((int'(rr_q) + i) % N_TARG_PORT);
      end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    port_d = port_q;
    en_d = en_q;
    s_d = s_q;
    t_d = t_q;
    active_d = active_q;
    app_src_d = app_src_q;
    app_tgt_d = app_tgt_q;
    case (state_q)
      IDLE: if (gnt_found) begin
        port_d = gnt_idx;
        en_d = desired_q[gnt_idx];
        s_d = src_q[int'(gnt_idx)*L +: L];
        t_d = tgt_q[int'(gnt_idx)*L +: L];
        rr_d = (gnt_idx == PW'(N_TARG_PORT - 1)) ? '0 : gnt_idx + 1'b1;
        state_d = DRAIN;
      end
      DRAIN: state_d = xbar_idle_i ? APPLY : expire ? IDLE : DRAIN;
      APPLY: if (cfg_ready_i) begin
        active_d[port_q] = en_q;
        app_src_d[int'(port_q)*L +: L] = s_q;
        app_tgt_d[int'(port_q)*L +: L] = t_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef REDIRECT_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic to_q;
  always_comb begin
    cnt_d = (state_q == DRAIN && !xbar_idle_i) ? cnt_q + 1'b1 : '0;
    expire = (state_q == DRAIN) && !xbar_idle_i && (cnt_q == CW'(DRAIN_TIMEOUT - 1));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q <= expire;
    end
  end
  assign timeout_o = to_q;
`else
  assign expire = 1'b0;
  assign timeout_o = 1'b0;
`endif
  assign cfg_valid_o = (state_q == APPLY);
  assign busy_o = (state_q != IDLE);
  assign cfg_port_o = port_q;
  assign cfg_enable_o = en_q;
  assign cfg_source_o = s_q;
  assign cfg_target_o = t_q;
  assign active_o = active_q;
endmodule

// File: tb/tb_redirect_sched.sv
// tb_redirect_sched: scoreboard bench for redirect_sched; expected routing updates queued at stimulus, checked at handshake.
module tb_redirect_sched;
  logic clk = 0, rst = 1;
  logic [6:0] valid = '0;
  logic [13:0] src = '0, tgt = '0;
  logic xbar_idle = 1, cfg_ready = 1;
  logic cfg_valid_o, cfg_enable_o, busy_o, timeout_o;
  logic [2:0] cfg_port_o;
  logic [1:0] cfg_source_o, cfg_target_o;
  logic [6:0] active_o;
  int n_tests = 0, n_fail = 0, n_valid = 0, n_to = 0;
  logic [7:0] exp_q[$];
  redirect_sched dut (
    .clk(clk), .rst(rst), .redirect_valid_i(valid), .source_i(src), .target_i(tgt),
    .xbar_idle_i(xbar_idle), .cfg_valid_o(cfg_valid_o), .cfg_ready_i(cfg_ready),
    .cfg_port_o(cfg_port_o), .cfg_enable_o(cfg_enable_o), .cfg_source_o(cfg_source_o),
    .cfg_target_o(cfg_target_o), .active_o(active_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] pk(input int p, input bit e, input int s, input int t);
    return {3'(p), e, 2'(s), 2'(t)};
  endfunction
  function automatic logic [7:0] payload();
    return {cfg_port_o, cfg_enable_o, cfg_source_o, cfg_target_o};
  endfunction
  always @(negedge clk) begin
    if (cfg_valid_o) n_valid++;
    if (timeout_o) n_to++;
    if (cfg_valid_o && cfg_ready) begin
      if (exp_q.size() == 0) chk("unexpected_xfer", {24'd0, payload()}, 32'hFFFF_FFFF);
      else chk("xfer", {24'd0, payload()}, {24'd0, exp_q.pop_front()});
    end
  end
  task automatic drive(input int p, input bit v, input int s, input int t, input bit push);
    valid[p] = v;
    src[p*2 +: 2] = 2'(s);
    tgt[p*2 +: 2] = 2'(t);
    if (push) exp_q.push_back(pk(p, v, s, t));
  endtask
  task automatic wait_quiet();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_o) return;
    end
    chk("quiet_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask
  initial begin
    int k;
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", cfg_valid_o, 0);
    chk("rst_active", active_o, 0);
    chk("rst_timeout", timeout_o, 0);
    @(posedge clk); #1 rst = 0;
    // single install: cfg_valid appears three cycles after input rise
    @(posedge clk); #1 drive(2, 1, 1, 3, 1);
    repeat (3) @(negedge clk);
    chk("lat_drain", cfg_valid_o, 0);
    @(negedge clk);
    chk("lat_apply", cfg_valid_o, 1);
    chk("lat_payload", payload(), pk(2, 1, 1, 3));
    wait_quiet();
    chk("t1_active", active_o, 7'b0000100);
    @(posedge clk); #1 drive(2, 0, 1, 3, 1);
    wait_quiet();
    chk("t2_active", active_o, 0);
    // round robin from a fresh pointer
    do_reset();
    @(posedge clk); #1 drive(0, 1, 0, 2, 1); drive(4, 1, 3, 0, 1);
    wait_quiet();
    chk("t3a_active", active_o, 7'b0010001);
    @(posedge clk); #1 drive(0, 0, 0, 2, 1); drive(4, 0, 3, 0, 1);
    wait_quiet();
    @(posedge clk); #1 drive(5, 1, 2, 3, 0); drive(0, 1, 0, 2, 0);
    exp_q.push_back(pk(5, 1, 2, 3)); exp_q.push_back(pk(0, 1, 0, 2));
    wait_quiet();
    chk("t3b_active", active_o, 7'b0100001);
    // backpressure holds payload
    @(posedge clk); #1 cfg_ready = 0; drive(6, 1, 2, 1, 1);
    k = 0;
    while (!cfg_valid_o && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", cfg_valid_o, 1);
      chk("bp_payload", payload(), pk(6, 1, 2, 1));
      @(negedge clk);
    end
    chk("bp_pending", exp_q.size(), 1);
    @(posedge clk); #1 cfg_ready = 1;
    wait_quiet();
    chk("t4_active", active_o, 7'b1100001);
    // reapply changed target without removal
    @(posedge clk); #1 drive(3, 1, 0, 1, 1);
    wait_quiet();
    @(posedge clk); #1 drive(3, 1, 0, 2, 1);
    wait_quiet();
    chk("t6_active", active_o, 7'b1101001);
    // async reset in APPLY
    @(posedge clk); #1 cfg_ready = 0; drive(1, 1, 3, 3, 0);
    k = 0;
    while (!cfg_valid_o && k < 20) begin @(negedge clk); k++; end
    chk("pre_rst_valid", cfg_valid_o, 1);
    #2 rst = 1;
    #1 chk("arst_valid", cfg_valid_o, 0);
    chk("arst_active", active_o, 0);
    chk("arst_busy", busy_o, 0);
    valid = '0; cfg_ready = 1;
    @(posedge clk); #1 rst = 0;
    // drain never completes
    @(posedge clk); #1 xbar_idle = 0; drive(5, 1, 1, 1, 0);
    k = 0;
    while (!busy_o && k < 10) begin @(negedge clk); k++; end
    chk("drain_entry", busy_o, 1);
    n_valid = 0; n_to = 0;
`ifdef REDIRECT_SCHED_TIMEOUT_EN
    k = 0;
    while (!timeout_o && k < 40) begin @(negedge clk); k++; end
    chk("to_latency", k, 16);
    @(negedge clk);
    chk("to_pulse_width", timeout_o, 0);
    chk("to_count", n_to, 1);
`else
    repeat (40) @(negedge clk);
    chk("nt_busy", busy_o, 1);
    chk("nt_timeout", n_to, 0);
`endif
    chk("to_no_valid", n_valid, 0);
    chk("to_active", active_o, 0);
    valid = '0; xbar_idle = 1;
    do_reset();
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
